// File: rtl/conf_master.sv
`default_nettype none
// ============================================================================
// Module   : conf_master
// Brief    : RS232 configuration-link initiator. Sends the five modulator
//            registers as a 'W' frame, or sends an 'R' frame, captures the
//            11-byte reply and compares it with the last written values.
// Revision : 1.0 - initial release
// ============================================================================
module conf_master #(
    parameter int TIMEOUT_CYC = 2000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_wr,
    input  logic        start_rd,
    input  logic [7:0]  w_control,
    input  logic [23:0] w_frec_mod,
    input  logic [23:0] w_frec_por,
    input  logic [15:0] w_im_am,
    input  logic [15:0] w_im_fm,
    output logic [7:0]  txdw,
    output logic        txena,
    input  logic        txbusy,
    input  logic [7:0]  rxdw,
    input  logic        rxrdy,
    output logic [7:0]  rd_control,
    output logic [23:0] rd_frec_mod,
    output logic [23:0] rd_frec_por,
    output logic [15:0] rd_im_am,
    output logic [15:0] rd_im_fm,
    output logic        busy,
    output logic        done,
    output logic        timeout,
    output logic        match
);

    localparam logic [7:0] c_HDR_WR = 8'h57;
    localparam logic [7:0] c_HDR_RD = 8'h52;
    localparam logic [3:0] c_LAST   = 4'd11;
    localparam int         c_TW     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_TX_LOAD    = 3'd1,
        S_TX_WAIT_HI = 3'd2,
        S_TX_WAIT_LO = 3'd3,
        S_RX_WAIT    = 3'd4,
        S_FINISH     = 3'd5
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [3:0]      r_cnt;
    logic [c_TW-1:0] r_timer;
    logic            r_is_wr;
    logic            r_to;
    logic [87:0]     r_shadow;
    logic [79:0]     r_shift;     // first ten reply bytes; the eleventh is merged on arrival
    logic [87:0]     r_rd;
    logic            r_match;

    logic            w_start;
    logic [6:0]      w_base;
    logic [7:0]      w_tx_byte;
    logic [87:0]     w_rx_word;

    assign w_start   = start_wr | start_rd;
    // Payload byte n (n = count-1) sits at bits [87-8n -: 8] of the shadow.
    assign w_base    = 7'd95 - {r_cnt, 3'b000};
    assign w_tx_byte = (r_cnt == 4'd0) ? (r_is_wr ? c_HDR_WR : c_HDR_RD)
                                       : r_shadow[w_base -: 8];
    assign w_rx_word = {r_shift, rxdw};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        txena       = 1'b0;
        txdw        = 8'h00;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_nxt = S_TX_LOAD;
                end
            end
            S_TX_LOAD: begin
                txdw = w_tx_byte;
                if (!txbusy) begin
                    txena       = 1'b1;
                    w_state_nxt = S_TX_WAIT_HI;
                end
            end
            S_TX_WAIT_HI: begin
                if (txbusy) begin
                    w_state_nxt = S_TX_WAIT_LO;
                end
            end
            S_TX_WAIT_LO: begin
                if (!txbusy) begin
                    if (!r_is_wr) begin
                        w_state_nxt = S_RX_WAIT;
                    end else if (r_cnt == c_LAST) begin
                        w_state_nxt = S_FINISH;
                    end else begin
                        w_state_nxt = S_TX_LOAD;
                    end
                end
            end
            S_RX_WAIT: begin
                // A full reply spends one cycle here so rd_* lead done by a cycle.
                if (r_cnt == c_LAST) begin
                    w_state_nxt = S_FINISH;
                end else if (!rxrdy && (r_timer == c_TMAX)) begin
                    w_state_nxt = S_FINISH;
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= '0;
            r_timer  <= '0;
            r_is_wr  <= 1'b0;
            r_to     <= 1'b0;
            r_shadow <= '0;
            r_shift  <= '0;
            r_rd     <= '0;
            r_match  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_cnt   <= '0;
                        r_to    <= 1'b0;
                        r_is_wr <= start_wr;
                        if (start_wr) begin
                            r_shadow <= {w_control, w_frec_mod, w_frec_por, w_im_am, w_im_fm};
                        end
                    end
                end
                S_TX_WAIT_LO: begin
                    if (!txbusy) begin
                        if (!r_is_wr) begin
                            r_cnt   <= '0;
                            r_timer <= '0;
                        end else if (r_cnt != c_LAST) begin
                            r_cnt <= r_cnt + 4'd1;
                        end
                    end
                end
                S_RX_WAIT: begin
                    if (r_cnt != c_LAST) begin
                        if (rxrdy) begin
                            r_shift <= {r_shift[71:0], rxdw};
                            r_cnt   <= r_cnt + 4'd1;
                            r_timer <= '0;
                            if (r_cnt == c_LAST - 4'd1) begin
                                r_rd    <= w_rx_word;
                                r_match <= (w_rx_word == r_shadow);
                            end
                        end else if (r_timer == c_TMAX) begin
                            r_to <= 1'b1;
                        end else begin
                            r_timer <= r_timer + c_TW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign {rd_control, rd_frec_mod, rd_frec_por, rd_im_am, rd_im_fm} = r_rd;
    assign busy    = (r_state != S_IDLE);
    assign done    = (r_state == S_FINISH);
    assign timeout = done & r_to;
    assign match   = r_match;

endmodule
`default_nettype wire

// File: tb/tb_conf_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_conf_master
// Brief    : Self-checking bench for conf_master with a UART/responder model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conf_master;

    localparam int TO = 100;

    logic        clk        = 1'b0;
    logic        rst        = 1'b1;
    logic        start_wr   = 1'b0;
    logic        start_rd   = 1'b0;
    logic [7:0]  w_control  = '0;
    logic [23:0] w_frec_mod = '0;
    logic [23:0] w_frec_por = '0;
    logic [15:0] w_im_am    = '0;
    logic [15:0] w_im_fm    = '0;
    logic [7:0]  txdw;
    logic        txena;
    logic        txbusy     = 1'b0;
    logic [7:0]  rxdw       = '0;
    logic        rxrdy      = 1'b0;
    logic [7:0]  rd_control;
    logic [23:0] rd_frec_mod;
    logic [23:0] rd_frec_por;
    logic [15:0] rd_im_am;
    logic [15:0] rd_im_fm;
    logic        busy;
    logic        done;
    logic        timeout;
    logic        match;

    always #5 clk = ~clk;

    conf_master #(.TIMEOUT_CYC(TO)) dut (
        .clk(clk), .rst(rst), .start_wr(start_wr), .start_rd(start_rd),
        .w_control(w_control), .w_frec_mod(w_frec_mod), .w_frec_por(w_frec_por),
        .w_im_am(w_im_am), .w_im_fm(w_im_fm),
        .txdw(txdw), .txena(txena), .txbusy(txbusy), .rxdw(rxdw), .rxrdy(rxrdy),
        .rd_control(rd_control), .rd_frec_mod(rd_frec_mod), .rd_frec_por(rd_frec_por),
        .rd_im_am(rd_im_am), .rd_im_fm(rd_im_fm),
        .busy(busy), .done(done), .timeout(timeout), .match(match)
    );

    // UART transmitter model: busy for tx_hold cycles after each strobe.
    int         tx_hold = 2;
    int         tx_left = 0;
    logic [7:0] tx_q[$];
    always @(posedge clk) begin
        logic       fire;
        logic [7:0] b;
        fire = txena;
        b    = txdw;
        #1;
        if (fire) begin
            tx_q.push_back(b);
            txbusy  = 1'b1;
            tx_left = tx_hold;
        end else if (txbusy) begin
            if (tx_left <= 1) txbusy = 1'b0;
            else              tx_left--;
        end
    end

    // Event monitor (values sampled are those of the cycle ending at this edge).
    int          cyc = 0, done_cnt = 0, done_cyc = 0, to_cnt = 0, stray_to = 0;
    int          txena_cnt = 0, viol = 0;
    bit          last_to = 1'b0, pend = 1'b0, seen_hi = 1'b0;
    logic [87:0] rd_prev = '0, rd_before_done = '0;
    always @(posedge clk) begin
        cyc++;
        if (done) begin
            done_cnt++;
            done_cyc       = cyc;
            last_to        = timeout;
            rd_before_done = rd_prev;
        end
        if (timeout) to_cnt++;
        if (timeout && !done) stray_to++;
        if (txena) begin
            txena_cnt++;
            if (pend) viol++;
            pend    = 1'b1;
            seen_hi = 1'b0;
        end else if (pend) begin
            if (txbusy)       seen_hi = 1'b1;
            else if (seen_hi) pend    = 1'b0;
        end
        rd_prev = {rd_control, rd_frec_mod, rd_frec_por, rd_im_am, rd_im_fm};
    end

    int         n_cmp = 0, n_err = 0;
    int         last_rx_cyc = 0;
    logic [7:0] wr_next  [11];
    logic [7:0] wr_bytes [11];
    logic [7:0] m_rd     [11];
    logic [7:0] rep      [11];
    bit         m_match = 1'b0;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [87:0] obs, input logic [87:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [87:0] flat(input logic [7:0] b [11]);
        logic [87:0] f;
        f = '0;
        for (int i = 0; i < 11; i++) f[87-8*i -: 8] = b[i];
        return f;
    endfunction

    function automatic logic [87:0] rd_now();
        return {rd_control, rd_frec_mod, rd_frec_por, rd_im_am, rd_im_fm};
    endfunction

    task automatic set_fields(input logic [7:0] c, input logic [23:0] fm, input logic [23:0] fp,
                              input logic [15:0] am, input logic [15:0] fi);
        w_control = c; w_frec_mod = fm; w_frec_por = fp; w_im_am = am; w_im_fm = fi;
        wr_next[0] = c;
        wr_next[1] = fm[23:16]; wr_next[2] = fm[15:8]; wr_next[3] = fm[7:0];
        wr_next[4] = fp[23:16]; wr_next[5] = fp[15:8]; wr_next[6] = fp[7:0];
        wr_next[7] = am[15:8];  wr_next[8] = am[7:0];
        wr_next[9] = fi[15:8];  wr_next[10] = fi[7:0];
    endtask

    task automatic rand_fields();
        set_fields(8'($urandom), 24'($urandom), 24'($urandom), 16'($urandom), 16'($urandom));
    endtask

    task automatic pulse(input logic wr, input logic rd);
        start_wr = wr;
        start_rd = rd;
        tick();
        start_wr = 1'b0;
        start_rd = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int limit);
        int n0, k;
        n0 = done_cnt;
        k  = 0;
        while (done_cnt == n0 && k < limit) begin
            tick();
            k++;
        end
        chk({tag, "_done"}, 88'(done_cnt - n0), 88'(1));
    endtask

    task automatic chk_frame(input string tag, input int base, input logic [7:0] hdr);
        chk({tag, "_len"}, 88'(tx_q.size() - base), 88'(12));
        for (int i = 0; i < 12; i++) begin
            if (base + i < tx_q.size()) begin
                if (i == 0) chk({tag, "_hdr"},  88'(tx_q[base]), 88'(hdr));
                else        chk({tag, "_byte"}, 88'(tx_q[base+i]), 88'(wr_bytes[i-1]));
            end
        end
    endtask

    task automatic do_write(input string tag, input int limit);
        int base, e0;
        base = tx_q.size();
        e0   = txena_cnt;
        wr_bytes = wr_next;
        pulse(1'b1, 1'b0);
        chk({tag, "_busy_rise"}, 88'(busy), 88'(1));
        wait_done(tag, limit);
        chk_frame(tag, base, 8'h57);
        chk({tag, "_txena_n"}, 88'(txena_cnt - e0), 88'(12));
        chk({tag, "_to"}, 88'(last_to), 88'(0));
    endtask

    // Sends 'R', answers with rep[0..nbytes-1], then checks against the model.
    task automatic do_read(input string tag, input int nbytes, input int gap_max);
        int  base, k;
        bit  eq;
        base = tx_q.size();
        pulse(1'b0, 1'b1);
        chk({tag, "_busy_rise"}, 88'(busy), 88'(1));
        k = 0;
        while ((tx_q.size() == base || txbusy) && k < 200) begin
            tick();
            k++;
        end
        chk({tag, "_hdr_n"}, 88'(tx_q.size() - base), 88'(1));
        if (tx_q.size() > base) chk({tag, "_hdr"}, 88'(tx_q[base]), 88'(8'h52));
        tick();
        for (int i = 0; i < nbytes; i++) begin
            rxdw  = rep[i];
            rxrdy = 1'b1;
            tick();
            rxrdy = 1'b0;
            last_rx_cyc = cyc;
            if (i < nbytes - 1) repeat ($urandom_range(0, gap_max)) tick();
        end
        if (nbytes == 11) begin
            m_rd = rep;
            eq   = 1'b1;
            for (int i = 0; i < 11; i++) if (rep[i] != wr_bytes[i]) eq = 1'b0;
            m_match = eq;
        end
        wait_done(tag, TO + 50);
        chk({tag, "_to"}, 88'(last_to), 88'(nbytes < 11));
        chk({tag, "_rd"}, rd_now(), flat(m_rd));
        chk({tag, "_rd_im_fm"}, 88'(rd_im_fm), 88'({m_rd[9], m_rd[10]}));
        chk({tag, "_match"}, 88'(match), 88'(m_match));
        if (nbytes == 11) begin
            chk({tag, "_rd_lead"}, rd_before_done, flat(m_rd));
        end else begin
            // done is high during the cycle that starts TO edges after the last byte's edge
            chk({tag, "_to_lat"}, 88'(done_cyc - last_rx_cyc), 88'(TO + 1));
        end
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog observed=no_finish expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, d0, k, idx;
        for (int i = 0; i < 11; i++) begin
            wr_bytes[i] = '0; m_rd[i] = '0; rep[i] = '0; wr_next[i] = '0;
        end

        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        chk("rst_busy",  88'(busy),  88'(0));
        chk("rst_done",  88'(done),  88'(0));
        chk("rst_txena", 88'(txena), 88'(0));
        chk("rst_txdw",  88'(txdw),  88'(0));
        chk("rst_to",    88'(timeout), 88'(0));
        chk("rst_match", 88'(match), 88'(0));
        chk("rst_rd",    rd_now(), 88'(0));

        tx_hold = 2;
        set_fields(8'h12, 24'h345678, 24'h9ABCDE, 16'hF011, 16'h2233);
        do_write("wr_dir", 400);

        rep = wr_bytes;
        do_read("rd_loop", 11, 3);
        chk("loop_match", 88'(match), 88'(1));

        rep = wr_bytes;
        idx = $urandom_range(0, 10);
        rep[idx] = rep[idx] ^ (8'd1 << $urandom_range(0, 7));
        do_read("rd_bad", 11, 3);
        chk("bad_match", 88'(match), 88'(0));

        d0 = done_cnt;
        rxdw  = 8'hA5;
        rxrdy = 1'b1;
        tick();
        rxrdy = 1'b0;
        repeat (5) tick();
        chk("idle_rx_rd",   rd_now(), flat(m_rd));
        chk("idle_rx_done", 88'(done_cnt - d0), 88'(0));

        for (int r = 0; r < 4; r++) begin
            tx_hold = $urandom_range(1, 4);
            rand_fields();
            do_write("wr_rnd", 400);
            rep = wr_bytes;
            if ($urandom_range(0, 1) == 1) begin
                idx = $urandom_range(0, 10);
                rep[idx] = rep[idx] ^ (8'd1 << $urandom_range(0, 7));
            end
            do_read("rd_rnd", 11, 4);
        end

        for (int i = 0; i < 11; i++) rep[i] = 8'($urandom);
        do_read("rd_timeout", 5, 3);

        rand_fields();
        wr_bytes = wr_next;
        base = tx_q.size();
        d0   = done_cnt;
        pulse(1'b1, 1'b1);
        repeat (3) tick();
        pulse(1'b0, 1'b1);
        wait_done("both", 400);
        chk_frame("both", base, 8'h57);
        repeat (40) tick();
        chk("both_no_extra", 88'(tx_q.size() - base), 88'(12));
        chk("both_one_done", 88'(done_cnt - d0), 88'(1));

        tx_hold = 3;
        rand_fields();
        wr_bytes = wr_next;
        base = tx_q.size();
        pulse(1'b1, 1'b0);
        k = 0;
        while (tx_q.size() - base < 4 && k < 200) begin
            tick();
            k++;
        end
        chk("rstmid_bytes", 88'(tx_q.size() - base), 88'(4));
        d0  = done_cnt;
        rst = 1'b1;
        tick();
        chk("rstmid_busy",  88'(busy),  88'(0));
        chk("rstmid_txena", 88'(txena), 88'(0));
        chk("rstmid_txdw",  88'(txdw),  88'(0));
        chk("rstmid_rd",    rd_now(),   88'(0));
        chk("rstmid_match", 88'(match), 88'(0));
        rst = 1'b0;
        for (int i = 0; i < 11; i++) begin
            wr_bytes[i] = '0; m_rd[i] = '0;
        end
        m_match = 1'b0;
        repeat (20) tick();
        chk("rstmid_no_done", 88'(done_cnt - d0), 88'(0));

        for (int i = 0; i < 11; i++) rep[i] = '0;
        do_read("rd_zero", 11, 1);
        rand_fields();
        do_write("wr_after_rst", 400);

        tx_hold = 1000;
        rand_fields();
        do_write("wr_slow", 12 * 1010 + 100);

        chk("txena_protocol", 88'(viol), 88'(0));
        chk("stray_timeout",  88'(stray_to), 88'(0));
        chk("timeout_count",  88'(to_cnt), 88'(1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conf_master.md
# conf_master

Configuration initiator for the RS232 configuration link. It drives the far end of the link: it serialises the five modulator configuration registers into a write frame, and issues read frames whose 11-byte reply is captured and compared against the last written values. It sits between a local byte UART (same txdw/txena/txbusy/rxdw/rxrdy handshake as the project's RS232 core) and a board-level test/loopback controller. It is used for board-to-board configuration and for loopback self-test of the configuration receiver.

## Interface
Parameters:
- TIMEOUT_CYC, 2000000, max clk cycles allowed between consecutive reply bytes of a read (40 ms at 50 MHz)

Ports (clock and reset first):
- clk  in  1  system clock; all logic on its rising edge
- rst  in  1  synchronous, active-high reset
- start_wr  in  1  1-cycle request: send write frame
- start_rd  in  1  1-cycle request: send read frame and capture reply
- w_control  in  8  control register value to write
- w_frec_mod  in  24  modulating frequency word
- w_frec_por  in  24  carrier frequency word
- w_im_am  in  16  AM index
- w_im_fm  in  16  FM index
- txdw  out  8  byte to UART transmitter
- txena  out  1  1-cycle transmit strobe
- txbusy  in  1  UART transmitter busy
- rxdw  in  8  byte from UART receiver
- rxrdy  in  1  1-cycle received-byte strobe
- rd_control / rd_frec_mod / rd_frec_por / rd_im_am / rd_im_fm  out  8/24/24/16/16  last complete read reply
- busy  out  1  frame in progress
- done  out  1  1-cycle pulse at end of any frame (success or timeout)
- timeout  out  1  1-cycle pulse, coincident with done, read aborted
- match  out  1  last completed read equals last written snapshot

## Operation
- Frame format (fixed): write = 0x57 ('W') + 11 payload bytes; read = 0x52 ('R'), responder returns 11 payload bytes. Payload order: control, frec_mod[23:16], [15:8], [7:0], frec_por[23:16], [15:8], [7:0], im_am[15:8], [7:0], im_fm[15:8], [7:0].
- States: IDLE, TX_LOAD, TX_WAIT_HI, TX_WAIT_LO, RX_WAIT, FINISH.
- IDLE: start_wr has priority over start_rd if both high. On start_wr the 88-bit w_* concatenation is snapshotted into a write shadow (held for match). On either start: busy=1, byte counter=0, go TX_LOAD.
- TX_LOAD: if txbusy=0 drive txdw (header for count 0, else payload byte count-1), txena=1 for one cycle, go TX_WAIT_HI; if txbusy=1 stay.
- TX_WAIT_HI: wait for txbusy=1. TX_WAIT_LO: wait for txbusy=0; then write frame: count<11 -> count+1, TX_LOAD; count=11 -> FINISH. Read frame: header sent -> count=0, timer=0, RX_WAIT.
- RX_WAIT: on rxrdy, shift rxdw into an 88-bit shift register (MSB first), count+1, timer=0; after 11th byte, copy shift register to rd_* outputs in one cycle, update match, go FINISH. Timer increments every cycle without rxrdy; reaching TIMEOUT_CYC-1 -> timeout=1, rd_* and match unchanged, FINISH.
- FINISH: done=1 for one cycle, busy=0, IDLE.
- start_wr/start_rd while busy=1 are ignored (not queued). rxrdy outside RX_WAIT is ignored.
- match = (captured 88 bits == write shadow); compared only on a completed read.

## Timing
- Reset: all outputs 0 (txdw=0, txena=0, rd_*=0, busy=0, done=0, timeout=0, match=0), write shadow=0, state IDLE. Reset mid-frame aborts immediately; no done pulse; a UART byte already strobed completes on the wire.
- busy rises the cycle after the start strobe is sampled.
- txena is asserted only in TX_LOAD with txbusy=0; never two txena without an intervening txbusy high-then-low.
- rd_* and match update on the same edge, one cycle before done.
- done falls after exactly one cycle; a new start is accepted in the cycle done is high? No: accepted from the first cycle busy=0 (the cycle after done).

## Test plan
- Write: w_control=0x12, w_frec_mod=0x345678, w_frec_por=0x9ABCDE, w_im_am=0xF011, w_im_fm=0x2233, start_wr -> txdw sequence 57 12 34 56 78 9A BC DE F0 11 22 33, 12 txena pulses, one done, timeout=0.
- Loopback read: after the write, responder model answers 'R' with the same 11 bytes -> rd_* equal written values, match=1, done pulse; corrupt one byte -> match=0.
- Timeout: TIMEOUT_CYC=100, responder sends 5 bytes then stops -> timeout and done pulse together 100 cycles after 5th byte, rd_* unchanged.
- Simultaneous start_wr=start_rd=1 -> write frame (0x57 header) only; start_rd during busy ignored.
- rst asserted after 4th byte of a write -> all outputs 0 next cycle, no done; fresh start_wr sends full 12-byte frame.
- Slow UART: txbusy held high 1000 cycles per byte -> no extra txena, byte order intact.
